ct_spsram_256x84_ctrl: RTL and testbench

Access controller that sits directly upstream of the 256x84 single-port SRAM wrapper and drives its CEN/GWEN/WEN/A/D pins.
- After reset, sweeps all 256 entries to INIT_VAL.
- Then accepts read/write requests on a valid/ready port.
- Returns read data through a 2-entry response buffer with backpressure.
- Used by the cache/predictor arrays that need a cleared table and a simple request interface instead of raw SRAM pins.

---
 rtl/ct_spsram_256x84_ctrl_pkg.sv | 8 +
 rtl/ct_spsram_256x84_rsp_fifo.sv | 30 +++
 rtl/ct_spsram_256x84_ctrl.sv | 67 ++++++
 tb/tb_ct_spsram_256x84_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ct_spsram_256x84_ctrl_pkg.sv
// ct_spsram_256x84_ctrl_pkg: shared geometry and state encoding for the SP-SRAM controller
package ct_spsram_256x84_ctrl_pkg;
  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 84;
  localparam int HALF_WIDTH = 42;
  localparam int DEPTH = 256;
  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/ct_spsram_256x84_rsp_fifo.sv
// ct_spsram_256x84_rsp_fifo: 2-entry in-order read response buffer with occupancy count
module ct_spsram_256x84_rsp_fifo
  import ct_spsram_256x84_ctrl_pkg::*;
(
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  vld,
  output logic [1:0]            cnt
);
  logic [DATA_WIDTH-1:0] mem [2];
  logic wp, rp;
  always_ff @(posedge forever_cpuclk)
    if (!cpurst_b) begin
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) wp <= ~wp;
      if (pop) rp <= ~rp;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  always_ff @(posedge forever_cpuclk)
    if (push) mem[wp] <= din;
  assign dout = mem[rp];
  assign vld = cnt != 2'd0;
endmodule

// File: rtl/ct_spsram_256x84_ctrl.sv
// ct_spsram_256x84_ctrl: clears the 256x84 SP-SRAM after reset, then serves valid/ready read/write requests
module ct_spsram_256x84_ctrl
  import ct_spsram_256x84_ctrl_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [1:0]            req_wmask,
  output logic                  rd_vld,
  input  logic                  rd_rdy,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  init_done,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);
  state_t state;
  logic [ADDR_WIDTH-1:0] sweep;
  logic inflight, xfer, wr, pop;
  logic [1:0] cnt;
  logic [2:0] credit;
  assign init_done = state == RUN;
  assign pop = rd_vld && rd_rdy;
  // an in-flight read already owns a buffer slot, so it counts against the credit
  assign credit = 3'(cnt) + 3'(inflight) - 3'(pop);
  assign req_rdy = init_done && credit < 3'd2;
  assign xfer = req_vld && req_rdy;
  assign wr = xfer && req_wr;
  always_comb begin
    sram_cen = init_done ? ~xfer : 1'b0;
    sram_gwen = init_done ? ~wr : 1'b0;
    sram_wen = !init_done ? '0 : wr ? {{HALF_WIDTH{~req_wmask[1]}}, {HALF_WIDTH{~req_wmask[0]}}} : '1;
    sram_a = init_done ? req_addr : sweep;
    sram_d = init_done ? req_wdata : INIT_VAL;
  end
  always_ff @(posedge forever_cpuclk)
    if (!cpurst_b) begin
      state <= INIT;
      sweep <= '0;
      inflight <= 1'b0;
    end else begin
      if (state == INIT) begin
        sweep <= sweep + 1'b1;
        if (sweep == {ADDR_WIDTH{1'b1}}) state <= RUN;
      end
      inflight <= xfer && !req_wr;
    end
  ct_spsram_256x84_rsp_fifo u_fifo (
    .forever_cpuclk(forever_cpuclk),
    .cpurst_b(cpurst_b),
    .push(inflight),
    .pop(pop),
    .din(sram_q),
    .dout(rd_data),
    .vld(rd_vld),
    .cnt(cnt)
  );
endmodule

// File: tb/tb_ct_spsram_256x84_ctrl.sv
// tb_ct_spsram_256x84_ctrl: randomized and directed checks of the SP-SRAM controller against a request-level model
module tb_ct_spsram_256x84_ctrl;
  logic forever_cpuclk = 1'b0;
  logic cpurst_b, req_vld, req_rdy, req_wr, rd_vld, rd_rdy, init_done, sram_cen, sram_gwen;
  logic [7:0] req_addr, sram_a;
  logic [83:0] req_wdata, rd_data, sram_wen, sram_d, sram_q;
  logic [1:0] req_wmask;
  logic [83:0] sram_mem [256];
  logic [83:0] ref_mem [256];
  logic [83:0] oq [$];
  int ot [$];
  int cyc = 0, run = 0, npass = 0, nchk = 0;
  bit e_vld, e_pop, e_rdy, e_init, xfer;
  logic [83:0] e_data;

  ct_spsram_256x84_ctrl dut (
    .forever_cpuclk(forever_cpuclk), .cpurst_b(cpurst_b),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_data(rd_data), .init_done(init_done),
    .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
    .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
  );

  always #5 forever_cpuclk = ~forever_cpuclk;

  // behavioural single-port SRAM with per-bit write enables
  always @(posedge forever_cpuclk)
    if (!sram_cen) begin
      if (!sram_gwen) sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else sram_q <= sram_mem[sram_a];
    end

  task sample();
    @(negedge forever_cpuclk);
    e_init = run >= 256;
    e_vld = oq.size() > 0 && ot[0] <= cyc - 2;
    e_data = '0;
    if (e_vld) e_data = oq[0];
    e_pop = e_vld && rd_rdy;
    e_rdy = e_init && (oq.size() - int'(e_pop)) < 2;
  endtask

  task advance();
    xfer = req_vld && e_rdy;
    @(posedge forever_cpuclk);
    if (!cpurst_b) begin
      oq.delete();
      ot.delete();
      run = 0;
      foreach (ref_mem[i]) ref_mem[i] = '0;
    end else begin
      if (e_pop) begin
        void'(oq.pop_front());
        void'(ot.pop_front());
      end
      if (xfer && req_wr) begin
        if (req_wmask[0]) ref_mem[req_addr][41:0] = req_wdata[41:0];
        if (req_wmask[1]) ref_mem[req_addr][83:42] = req_wdata[83:42];
      end else if (xfer) begin
        oq.push_back(ref_mem[req_addr]);
        ot.push_back(cyc);
      end
      run++;
    end
    cyc++;
    #1;
  endtask

  task put(input bit w, input logic [7:0] a, input logic [83:0] d, input logic [1:0] m);
    req_vld = 1'b1;
    req_wr = w;
    req_addr = a;
    req_wdata = d;
    req_wmask = m;
  endtask

  task test_reset();
    cpurst_b = 1'b0;
    repeat (3) begin
      sample();
      advance();
    end
    sample();
    nchk++; if (init_done !== 1'b0) $display("FAIL reset_init_done got %b exp 0", init_done); else npass++;
    nchk++; if (req_rdy !== 1'b0) $display("FAIL reset_req_rdy got %b exp 0", req_rdy); else npass++;
    nchk++; if (rd_vld !== 1'b0) $display("FAIL reset_rd_vld got %b exp 0", rd_vld); else npass++;
    advance();
    cpurst_b = 1'b1;
  endtask

  task test_init();
    logic [179:0] got, exp;
    put(0, 8'($urandom), '0, 2'b11);
    for (int i = 0; i < 256; i++) begin
      sample();
      got = {sram_cen, sram_gwen, sram_wen, sram_a, sram_d, req_rdy, init_done};
      exp = {1'b0, 1'b0, 84'b0, 8'(i), 84'b0, 1'b0, 1'b0};
      nchk++; if (got !== exp) $display("FAIL init_cycle_%0d got %h exp %h", i, got, exp); else npass++;
      advance();
      req_addr = 8'($urandom);
    end
    req_vld = 1'b0;
    sample();
    nchk++; if (init_done !== 1'b1) $display("FAIL init_done_at_256 got %b exp 1", init_done); else npass++;
    nchk++; if (req_rdy !== e_rdy) $display("FAIL init_rdy_at_256 got %b exp %b", req_rdy, e_rdy); else npass++;
    nchk++; if ({sram_cen, sram_gwen, sram_wen} !== {2'b11, {84{1'b1}}}) $display("FAIL idle_pins got %b%b %h", sram_cen, sram_gwen, sram_wen); else npass++;
    advance();
  endtask

  task test_mask();
    logic [83:0] exp_m;
    exp_m = {{42{1'b1}}, 42'b0};
    rd_rdy = 1'b1;
    put(1, 8'h10, '1, 2'b11);
    sample();
    nchk++; if ({sram_cen, sram_gwen, sram_wen, req_rdy} !== {2'b00, 84'b0, 1'b1}) $display("FAIL mask_wr11 got %b%b %h %b", sram_cen, sram_gwen, sram_wen, req_rdy); else npass++;
    advance();
    put(1, 8'h10, '0, 2'b01);
    sample();
    nchk++; if ({sram_cen, sram_gwen, sram_wen} !== {2'b00, exp_m}) $display("FAIL mask_wr01 got %b%b %h exp %h", sram_cen, sram_gwen, sram_wen, exp_m); else npass++;
    advance();
    put(0, 8'h10, '0, 2'b00);
    sample();
    nchk++; if ({sram_cen, sram_gwen, sram_wen, sram_a} !== {2'b01, {84{1'b1}}, 8'h10}) $display("FAIL mask_rd_pins got %b%b %h %h", sram_cen, sram_gwen, sram_wen, sram_a); else npass++;
    advance();
    req_vld = 1'b0;
    sample();
    nchk++; if (rd_vld !== 1'b0) $display("FAIL mask_rd_early got %b exp 0", rd_vld); else npass++;
    advance();
    sample();
    nchk++; if (rd_vld !== 1'b1 || rd_data !== exp_m) $display("FAIL mask_rd_data got %b %h exp 1 %h", rd_vld, rd_data, exp_m); else npass++;
    advance();
  endtask

  task test_back_to_back();
    int n;
    n = 0;
    rd_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      put(1, 8'(i), 84'(i), 2'b11);
      sample();
      advance();
    end
    for (int i = 0; i < 12; i++) begin
      if (i < 8) put(0, 8'(i), '0, 2'b00);
      else req_vld = 1'b0;
      sample();
      if (i < 8) begin
        nchk++; if (req_rdy !== 1'b1) $display("FAIL b2b_rdy_%0d got %b exp 1", i, req_rdy); else npass++;
      end
      if (i >= 2 && i < 10) begin
        nchk++; if (rd_vld !== 1'b1 || rd_data !== 84'(n)) $display("FAIL b2b_data_%0d got %b %h exp 1 %h", i, rd_vld, rd_data, 84'(n)); else npass++;
      end
      if (rd_vld) n++;
      advance();
    end
    nchk++; if (n !== 8) $display("FAIL b2b_count got %0d exp 8", n); else npass++;
  endtask

  task test_raw();
    rd_rdy = 1'b1;
    put(1, 8'h20, 84'h5A, 2'b11);
    sample();
    advance();
    put(0, 8'h20, '0, 2'b00);
    sample();
    advance();
    req_vld = 1'b0;
    sample();
    advance();
    sample();
    nchk++; if (rd_vld !== 1'b1 || rd_data !== 84'h5A) $display("FAIL raw got %b %h exp 1 5a", rd_vld, rd_data); else npass++;
    advance();
  endtask

  task test_backpressure();
    int acc, n;
    bit seen;
    logic [83:0] hold;
    logic [7:0] a;
    acc = 0; n = 0; seen = 0; a = 0; hold = '0;
    rd_rdy = 1'b0;
    for (int k = 0; k < 8; k++) begin
      put(0, a, '0, 2'b00);
      sample();
      nchk++; if (req_rdy !== e_rdy) $display("FAIL bp_rdy_%0d got %b exp %b", k, req_rdy, e_rdy); else npass++;
      nchk++; if (rd_vld !== e_vld) $display("FAIL bp_vld_%0d got %b exp %b", k, rd_vld, e_vld); else npass++;
      if (e_vld) begin
        nchk++; if (rd_data !== e_data) $display("FAIL bp_data_%0d got %h exp %h", k, rd_data, e_data); else npass++;
      end
      if (seen) begin
        nchk++; if (rd_data !== hold) $display("FAIL bp_stable_%0d got %h exp %h", k, rd_data, hold); else npass++;
      end
      if (rd_vld && !seen) begin
        seen = 1;
        hold = rd_data;
      end
      if (e_rdy) begin
        acc++;
        a++;
      end
      advance();
    end
    nchk++; if (acc !== 2) $display("FAIL bp_accepted got %0d exp 2", acc); else npass++;
    req_vld = 1'b0;
    rd_rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      sample();
      nchk++; if (rd_vld !== e_vld) $display("FAIL drain_vld_%0d got %b exp %b", k, rd_vld, e_vld); else npass++;
      if (e_vld) begin
        nchk++; if (rd_data !== e_data) $display("FAIL drain_data_%0d got %h exp %h", k, rd_data, e_data); else npass++;
      end
      if (rd_vld) n++;
      advance();
    end
    nchk++; if (n !== 2) $display("FAIL drain_count got %0d exp 2", n); else npass++;
  endtask

  task test_random();
    for (int k = 0; k < 400; k++) begin
      req_vld = 1'($urandom);
      req_wr = 1'($urandom);
      req_addr = 8'($urandom_range(0, 15));
      req_wdata = 84'({$urandom(), $urandom(), $urandom()});
      req_wmask = 2'($urandom);
      rd_rdy = $urandom_range(0, 3) != 0;
      sample();
      nchk++; if (req_rdy !== e_rdy) $display("FAIL rnd_rdy_%0d got %b exp %b", k, req_rdy, e_rdy); else npass++;
      nchk++; if (rd_vld !== e_vld) $display("FAIL rnd_vld_%0d got %b exp %b", k, rd_vld, e_vld); else npass++;
      if (e_vld) begin
        nchk++; if (rd_data !== e_data) $display("FAIL rnd_data_%0d got %h exp %h", k, rd_data, e_data); else npass++;
      end
      nchk++; if (sram_cen !== !(req_vld && e_rdy)) $display("FAIL rnd_cen_%0d got %b exp %b", k, sram_cen, !(req_vld && e_rdy)); else npass++;
      advance();
    end
    req_vld = 1'b0;
    rd_rdy = 1'b1;
    repeat (4) begin
      sample();
      advance();
    end
  endtask

  task test_reset_mid_init();
    req_vld = 1'b0;
    cpurst_b = 1'b0;
    sample();
    advance();
    cpurst_b = 1'b1;
    repeat (100) begin
      sample();
      advance();
    end
    sample();
    nchk++; if (sram_a !== 8'd100) $display("FAIL mid_init_addr got %0d exp 100", sram_a); else npass++;
    cpurst_b = 1'b0;
    advance();
    cpurst_b = 1'b1;
    for (int i = 0; i < 257; i++) begin
      sample();
      if (i == 0) begin
        nchk++; if (sram_a !== 8'd0 || sram_cen !== 1'b0) $display("FAIL restart_addr got %0d cen %b exp 0 0", sram_a, sram_cen); else npass++;
      end
      nchk++; if (init_done !== (i == 256)) $display("FAIL restart_done_%0d got %b exp %b", i, init_done, i == 256); else npass++;
      advance();
    end
  endtask

  task test_reset_run();
    rd_rdy = 1'b0;
    put(0, 8'h01, '0, 2'b00);
    sample();
    advance();
    put(0, 8'h02, '0, 2'b00);
    sample();
    advance();
    req_vld = 1'b0;
    sample();
    advance();
    sample();
    nchk++; if (rd_vld !== 1'b1 || oq.size() != 2) $display("FAIL run_buffered got %b exp 1 (model %0d)", rd_vld, oq.size()); else npass++;
    cpurst_b = 1'b0;
    advance();
    cpurst_b = 1'b1;
    sample();
    nchk++; if (rd_vld !== 1'b0) $display("FAIL run_reset_vld got %b exp 0", rd_vld); else npass++;
    nchk++; if (init_done !== 1'b0) $display("FAIL run_reset_done got %b exp 0", init_done); else npass++;
    advance();
  endtask

  initial begin
    cpurst_b = 1'b0;
    req_vld = 1'b0;
    req_wr = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_wmask = '0;
    rd_rdy = 1'b1;
    test_reset();
    test_init();
    test_mask();
    test_back_to_back();
    test_raw();
    test_backpressure();
    test_random();
    test_reset_mid_init();
    test_reset_run();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
